// File: rtl/pending_dispatch_256_pkg.sv
// Shared constants, FSM state type and index decode for the pending/dispatch stage
// that sits in front of the 256-bit priority encoder.
package pending_dispatch_256_pkg;

  localparam int N  = 256;
  localparam int IW = 8;
  localparam int CW = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/pending_dispatch_256.sv
// Holds request pulses in a pending bitmap, presents the enabled subset to an external
// priority encoder and hands each winning index downstream over a valid/ready handshake.
module pending_dispatch_256
  import pending_dispatch_256_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_vec,
  input  logic          en_wr,
  input  logic [IW-1:0] en_idx,
  input  logic          en_val,
  input  logic          flush,
  output logic [N-1:0]  pend_vec,
  input  logic [IW-1:0] enc_idx,
  input  logic          enc_gs,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx,
  input  logic          gnt_ready,
  output logic [CW-1:0] coal_cnt
);

  logic [N-1:0] pending;
  logic [N-1:0] enable;
  logic [N-1:0] clr;
  logic [N-1:0] pending_next;
  logic         cap;
  logic         coal_hit;
  state_t       state;
  state_t       state_next;

  assign pend_vec  = pending & enable;
  assign gnt_valid = (state == OFFER);

  // A new index is taken whenever the output slot is free or being vacated this cycle;
  // flush blocks capture so the cleared bitmap cannot leak a stale winner.
  always_comb begin
    state_next = state;
    cap        = 1'b0;
    clr        = '0;
    case (state)
      IDLE: begin
        if (enc_gs && !flush) begin
          cap        = 1'b1;
          state_next = OFFER;
        end
      end
      OFFER: begin
        if (gnt_ready) begin
          if (enc_gs && !flush) cap = 1'b1;
          else                  state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (cap) clr = onehot(enc_idx);
    // OR-ing req_vec last lets a same-cycle re-raise survive its own clear
    pending_next = flush ? req_vec : ((pending & ~clr) | req_vec);
    coal_hit     = |(req_vec & pending & ~clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      enable   <= '1;
      gnt_idx  <= '0;
      coal_cnt <= '0;
    end else begin
      pending <= pending_next;
      if (en_wr) enable[en_idx] <= en_val;
      if (cap)   gnt_idx <= enc_idx;
      if (coal_hit && (coal_cnt != '1)) coal_cnt <= coal_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_pending_dispatch_256.sv
// Self-checking bench: behavioural encoder, bitmap-level reference model, directed table,
// hand-written corner sequences and a randomized run.
module tb_pending_dispatch_256;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] req_vec;
  logic         en_wr;
  logic [7:0]   en_idx;
  logic         en_val;
  logic         flush;
  logic [255:0] pend_vec;
  logic [7:0]   enc_idx;
  logic         enc_gs;
  logic         gnt_valid;
  logic [7:0]   gnt_idx;
  logic         gnt_ready;
  logic [15:0]  coal_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  bit [255:0] m_pend;
  bit         m_en [256];
  bit         m_offer;
  int         m_idx;
  int         m_coal;
  int         accepted [$];

  typedef struct {
    logic [255:0] req;
    bit           ready;
    bit           exp_valid;
    int           exp_idx;
    logic [255:0] exp_pend;
  } vec_t;

  vec_t tbl [$];

  pending_dispatch_256 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_vec   (req_vec),
    .en_wr     (en_wr),
    .en_idx    (en_idx),
    .en_val    (en_val),
    .flush     (flush),
    .pend_vec  (pend_vec),
    .enc_idx   (enc_idx),
    .enc_gs    (enc_gs),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .gnt_ready (gnt_ready),
    .coal_cnt  (coal_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in for the external priority encoder: highest set bit wins.
  always_comb begin
    enc_gs  = 1'b0;
    enc_idx = '0;
    for (int i = 0; i < 256; i++) begin
      if (pend_vec[i]) begin
        enc_gs  = 1'b1;
        enc_idx = 8'(i);
      end
    end
  end

  function automatic logic [255:0] oh(input int i);
    logic [255:0] one;
    one = 256'd1;
    return one << i;
  endfunction

  function automatic vec_t mk(input logic [255:0] req, input bit ready, input bit ev,
                              input int eidx, input logic [255:0] epend);
    vec_t v;
    v.req = req; v.ready = ready; v.exp_valid = ev; v.exp_idx = eidx; v.exp_pend = epend;
    return v;
  endfunction

  task automatic check_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend  = '0;
    foreach (m_en[i]) m_en[i] = 1'b1;
    m_offer = 1'b0;
    m_idx   = 0;
    m_coal  = 0;
  endtask

  function automatic logic [255:0] model_vis();
    logic [255:0] v;
    for (int i = 0; i < 256; i++) v[i] = m_pend[i] & m_en[i];
    return v;
  endfunction

  function automatic int model_top();
    for (int i = 255; i >= 0; i--) if (m_pend[i] && m_en[i]) return i;
    return -1;
  endfunction

  // One clock of the reference model, driven by the inputs currently applied.
  task automatic model_advance();
    int         hi;
    bit         cap;
    bit         hit;
    bit         taken;
    bit [255:0] nxt;
    hi  = model_top();
    cap = (hi >= 0) && !flush && (!m_offer || gnt_ready);
    hit = 1'b0;
    for (int i = 0; i < 256; i++) begin
      taken = cap && (i == hi);
      if (req_vec[i] && m_pend[i] && !taken) hit = 1'b1;
      nxt[i] = flush ? req_vec[i] : ((m_pend[i] && !taken) || req_vec[i]);
    end
    if (hit && m_coal < 65535) m_coal++;
    if (cap) begin
      m_offer = 1'b1;
      m_idx   = hi;
    end else if (m_offer && gnt_ready) begin
      m_offer = 1'b0;
    end
    if (en_wr) m_en[en_idx] = en_val;
    m_pend = nxt;
  endtask

  task automatic check_output();
    check_vec("pend_vec", pend_vec, model_vis());
    check_int("gnt_valid", gnt_valid, m_offer);
    check_int("gnt_idx", gnt_idx, m_idx);
    check_int("coal_cnt", coal_cnt, m_coal);
  endtask

  task automatic apply_stimulus(input logic [255:0] req, input bit ready, input bit flsh,
                                input bit wr, input int widx, input bit wval);
    req_vec   = req;
    gnt_ready = ready;
    flush     = flsh;
    en_wr     = wr;
    en_idx    = 8'(widx);
    en_val    = wval;
  endtask

  task automatic sample();
    @(negedge clk);
    if (gnt_valid === 1'b1 && gnt_ready) accepted.push_back(int'(gnt_idx));
  endtask

  task automatic end_cycle();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit do_check);
    sample();
    if (do_check) check_output();
    end_cycle();
  endtask

  function automatic int acc_at(input int k);
    return (accepted.size() > k) ? accepted[k] : -1;
  endfunction

  function automatic int pick();
    int pool [6] = '{0, 1, 63, 128, 254, 255};
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 255));
    return pool[$urandom_range(0, 5)];
  endfunction

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [255:0] r;
    int           n;

    // reset state
    apply_stimulus('0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #12;
    check_output();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single pulse, priority/back-to-back, backpressure
    tbl.push_back(mk(oh(5), 1, 0, -1, '0));
    tbl.push_back(mk('0, 1, 0, -1, oh(5)));
    tbl.push_back(mk('0, 1, 1, 5, '0));
    tbl.push_back(mk('0, 1, 0, -1, '0));
    tbl.push_back(mk(oh(3) | oh(200) | oh(17), 1, 0, -1, '0));
    tbl.push_back(mk('0, 1, 0, -1, oh(3) | oh(200) | oh(17)));
    tbl.push_back(mk('0, 1, 1, 200, oh(3) | oh(17)));
    tbl.push_back(mk('0, 1, 1, 17, oh(3)));
    tbl.push_back(mk('0, 1, 1, 3, '0));
    tbl.push_back(mk('0, 1, 0, -1, '0));
    tbl.push_back(mk(oh(10) | oh(9), 0, 0, -1, '0));
    tbl.push_back(mk('0, 0, 0, -1, oh(10) | oh(9)));
    for (int k = 0; k < 5; k++) tbl.push_back(mk('0, 0, 1, 10, oh(9)));
    tbl.push_back(mk('0, 1, 1, 10, oh(9)));
    tbl.push_back(mk('0, 1, 1, 9, '0));
    tbl.push_back(mk('0, 1, 0, -1, '0));

    foreach (tbl[k]) begin
      apply_stimulus(tbl[k].req, tbl[k].ready, 1'b0, 1'b0, 0, 1'b0);
      sample();
      check_int("tbl_valid", gnt_valid, tbl[k].exp_valid);
      if (tbl[k].exp_idx >= 0) check_int("tbl_idx", gnt_idx, tbl[k].exp_idx);
      check_vec("tbl_pend", pend_vec, tbl[k].exp_pend);
      check_output();
      end_cycle();
    end

    // masked line 255 waits until re-enabled
    accepted.delete();
    apply_stimulus('0, 1, 0, 1, 255, 0);     step(1);
    apply_stimulus(oh(255) | oh(1), 1, 0, 0, 0, 0); step(1);
    apply_stimulus('0, 1, 0, 0, 0, 0);       step(1); step(1);
    apply_stimulus('0, 1, 0, 1, 255, 1);     step(1);
    apply_stimulus('0, 1, 0, 0, 0, 0);
    repeat (4) step(1);
    check_int("mask_count", accepted.size(), 2);
    check_int("mask_first", acc_at(0), 1);
    check_int("mask_second", acc_at(1), 255);

    // re-raise in the capture cycle: dispatched twice, not coalesced
    accepted.delete();
    apply_stimulus(oh(1), 1, 0, 0, 0, 0); step(1); step(1);
    apply_stimulus('0, 1, 0, 0, 0, 0);
    repeat (4) step(1);
    check_int("collide_count", accepted.size(), 2);
    check_int("collide_first", acc_at(0), 1);
    check_int("collide_second", acc_at(1), 1);
    check_int("collide_coal", coal_cnt, 0);

    // flush while 4 is offered and 8 is pending
    accepted.delete();
    apply_stimulus(oh(4), 0, 0, 0, 0, 0); step(1);
    apply_stimulus('0, 0, 0, 0, 0, 0);    step(1);
    apply_stimulus(oh(8), 0, 0, 0, 0, 0); step(1);
    apply_stimulus('0, 0, 1, 0, 0, 0);    step(1);
    apply_stimulus('0, 1, 0, 0, 0, 0);
    repeat (3) step(1);
    check_int("flush_count", accepted.size(), 1);
    check_int("flush_idx", acc_at(0), 4);
    check_vec("flush_pend", pend_vec, '0);
    check_int("flush_valid", gnt_valid, 0);

    // coalescing on a masked line, then saturation
    apply_stimulus('0, 1, 0, 1, 40, 0); step(1);
    apply_stimulus(oh(40), 1, 0, 0, 0, 0);
    repeat (4) step(1);
    apply_stimulus('0, 1, 0, 0, 0, 0); step(1);
    check_int("coal_three", coal_cnt, 3);
    apply_stimulus(oh(40), 1, 0, 0, 0, 0);
    repeat (70000) step(0);
    apply_stimulus('0, 1, 0, 0, 0, 0); step(1);
    check_int("coal_saturate", coal_cnt, 65535);

    // asynchronous reset in the middle of an offer
    apply_stimulus(oh(7), 0, 0, 0, 0, 0); step(1);
    apply_stimulus('0, 0, 0, 0, 0, 0);    step(1);
    check_int("offer_before_reset", gnt_valid, 1);
    check_int("offer_idx_before_reset", gnt_idx, 7);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_int("rst_valid", gnt_valid, 0);
    check_int("rst_idx", gnt_idx, 0);
    check_vec("rst_pend", pend_vec, '0);
    check_int("rst_coal", coal_cnt, 0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    apply_stimulus('0, 1, 0, 0, 0, 0);
    step(1);

    // randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      r = '0;
      if ($urandom_range(0, 2) == 0) begin
        n = int'($urandom_range(1, 3));
        for (int k = 0; k < n; k++) r[pick()] = 1'b1;
      end
      apply_stimulus(r, $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
                     $urandom_range(0, 7) == 0, pick(), $urandom_range(0, 2) != 0);
      step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
